mmio_input_responder: RTL and testbench
=======================================

MMIO_INPUT_RESPONDER -- requirements
Module: mmio_input_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_2000: 16-byte-aligned base of the register window.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable cycles required before a debounced input bit changes (range 2..65535).
REQ-003 Port Clk, input, 1: the single clock; every register in the block is clocked on its rising edge.
REQ-004 Port Rst, input, 1: synchronous, active-high reset.
REQ-005 Port MemRead, input, 1: load request from the CPU memory stage.
REQ-006 Port MemWrite, input, 1: store request from the CPU memory stage.
REQ-007 Port Address, input, 32: byte address of the access.
REQ-008 Port WriteData, input, 32: store data.
REQ-009 Port Sw, input, 16: raw, asynchronous slide-switch inputs.
REQ-010 Port Btn, input, 5: raw, asynchronous push-button inputs.
REQ-011 Port Hit, output, 1: asserted when Address falls inside the window.
REQ-012 Port ReadData, output, 32: load response data.
REQ-013 Port Led, output, 16: LED register contents.
REQ-014 Port IrqPending, output, 1: OR of all button-event bits.

Function
REQ-015 Hit SHALL be combinational and equal (Address[31:4] == BASE_ADDR[31:4]); Address[1:0] is ignored.
REQ-016 Register map by Address[3:2]:
- 0: SW, read-only, {16'b0, debounced Sw}
- 1: BTN, read-only, {27'b0, debounced Btn}
- 2: EVT, {27'b0, event bits}, write-1-to-clear
- 3: LED, read/write, {16'b0, Led}
REQ-017 ReadData SHALL be combinational (zero-latency, same cycle as MemRead) and SHALL be 0 when Hit=0 or MemRead=0.
REQ-018 When MemRead=1 and MemWrite=1 in the same cycle, the access is treated as a write only, and ReadData SHALL be 0.
REQ-019 A store with Hit=1 to LED SHALL load WriteData[15:0] into Led at the next edge; stores to SW or BTN have no effect.
REQ-020 Each Sw and Btn bit SHALL pass through a 2-flop synchronizer before it is used.
REQ-021 Each input bit SHALL have its own debounce counter:
- The counter resets to 0 whenever the synchronized bit equals the debounced bit, or when the synchronized bit changes.
- The counter increments by 1 in each cycle the synchronized bit differs from the debounced bit.
- On reaching DEBOUNCE_CYCLES-1, the debounced bit takes the synchronized value and the counter clears.
REQ-022 Counter width is clog2(DEBOUNCE_CYCLES), and counters SHALL NOT wrap.
REQ-023 Latency from a stable raw change to a debounced change is exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-024 A 0->1 transition of a debounced Btn bit SHALL set the corresponding EVT bit at the same edge.
REQ-025 A write with Hit=1 to EVT SHALL clear every bit where WriteData[i]=1.
REQ-026 If a set and a clear hit the same EVT bit in the same cycle, the set wins.
REQ-027 A read of EVT SHALL NOT modify it.
REQ-028 IrqPending SHALL be a registered output, updated one cycle after the EVT bits.

Reset
REQ-029 While Rst=1 at an edge, all of the following SHALL be cleared to 0: synchronizers, debounced values, counters, EVT, Led, and IrqPending.
REQ-030 Reset asserted mid-debounce SHALL discard any partial count; after release, debouncing restarts from 0.
REQ-031 Hit and ReadData SHALL remain combinational during reset and reflect the cleared state.

Configuration
REQ-032 Macro BTN_EVENT_EN controls the event logic.
- Defined: the EVT register and IrqPending behave as described in REQ-024..REQ-028.
- Undefined: no EVT storage exists, offset 2 reads 0, writes to offset 2 are ignored, and IrqPending is constant 0.

Verification
REQ-033 Reset: Rst=1 for 2 cycles, then a load at 0x200C -> ReadData=0, Led=0, IrqPending=0.
REQ-034 LED round trip: store 0xABCD_1234 to 0x200C -> Led=0x1234 at the next edge; a load at 0x200C returns 0x0000_1234; a load at 0x3000 gives Hit=0 and ReadData=0.
REQ-035 Debounce, with DEBOUNCE_CYCLES=16:
- Sw[3] toggles every 5 cycles for 100 cycles -> SW register stays 0.
- Sw[3] held at 1 -> SW register reads 0x8 exactly 18 cycles after the change.
REQ-036 Button event, with BTN_EVENT_EN defined:
- Btn[2] pulse held 30 cycles -> EVT=0x4, and IrqPending=1 one cycle later.
- Store 0x4 to 0x2008 -> EVT=0, and IrqPending=0 one cycle later.
REQ-037 Set/clear collision: the debounced Btn[0] rise coincides with a store of 0x1 to 0x2008 -> EVT[0] remains 1.
REQ-038 Simultaneous read and write: MemRead=1 and MemWrite=1 with 0x55 to 0x200C -> ReadData=0 that cycle, and Led=0x0055 at the next edge.

Source files
------------

// File: rtl/mmio_input_responder.sv
// Memory-mapped switch/button/LED block: 2-flop synchronizers, per-bit debounce, LED register,
// and optional latched button events with a registered interrupt (enabled by BTN_EVENT_EN).
module mmio_input_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [15:0] Sw,
  input  logic [4:0]  Btn,
  output logic        Hit,
  output logic [31:0] ReadData,
  output logic [15:0] Led,
  output logic        IrqPending
);

  localparam int NUM_IN = 21;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SEL_SW  = 2'd0;
  localparam logic [1:0] SEL_BTN = 2'd1;
  localparam logic [1:0] SEL_EVT = 2'd2;
  localparam logic [1:0] SEL_LED = 2'd3;

  logic [NUM_IN-1:0] rawIn;
  logic [NUM_IN-1:0] syncStage1Reg;
  logic [NUM_IN-1:0] syncStage2Reg;
  logic [NUM_IN-1:0] debReg;
  logic [NUM_IN-1:0] debNext;
  logic [15:0]       ledReg;
  logic [4:0]        evtView;
  logic [1:0]        regSel;
  logic              writeHit;
  logic              readHit;

  // Address bits that never select anything; kept visible so lint sees them consumed.
  logic unusedBits;
  assign unusedBits = &{1'b0, Address[1:0], WriteData[31:16]};

  assign rawIn    = {Btn, Sw};
  assign Hit      = (Address[31:4] == BASE_ADDR[31:4]);
  assign regSel   = Address[3:2];
  assign writeHit = MemWrite & Hit;
  assign readHit  = MemRead & ~MemWrite & Hit;
  assign Led      = ledReg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      syncStage1Reg <= '0;
      syncStage2Reg <= '0;
      debReg        <= '0;
    end else begin
      syncStage1Reg <= rawIn;
      syncStage2Reg <= syncStage1Reg;
      debReg        <= debNext;
    end
  end

  // One saturating-by-construction counter per input bit; it clears before it could wrap.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_debounce
      logic [CNT_W-1:0] cntReg;
      logic [CNT_W-1:0] cntNext;
      logic             debBitNext;

      always_comb begin
        cntNext    = cntReg;
        debBitNext = debReg[gi];
        if (syncStage2Reg[gi] == debReg[gi]) begin
          cntNext = '0;
        end else if (cntReg == CNT_LAST) begin
          debBitNext = syncStage2Reg[gi];
          cntNext    = '0;
        end else if (syncStage1Reg[gi] != syncStage2Reg[gi]) begin
          // Synchronized bit is about to move: restart the stability window.
          cntNext = '0;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end

      always_ff @(posedge Clk) begin
        if (Rst) begin
          cntReg <= '0;
        end else begin
          cntReg <= cntNext;
        end
      end

      assign debNext[gi] = debBitNext;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ledReg <= '0;
    end else if (writeHit && (regSel == SEL_LED)) begin
      ledReg <= WriteData[15:0];
    end
  end

`ifdef BTN_EVENT_EN
  logic [4:0] evtReg;
  logic [4:0] evtNext;
  logic [4:0] btnRise;
  logic [4:0] evtClear;
  logic       irqReg;

  assign btnRise  = debNext[20:16] & ~debReg[20:16];
  assign evtClear = (writeHit && (regSel == SEL_EVT)) ? WriteData[4:0] : 5'd0;

  // Set is applied after clear so a coincident rise survives a write-1-to-clear.
  always_comb begin
    evtNext = (evtReg & ~evtClear) | btnRise;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      evtReg <= '0;
      irqReg <= 1'b0;
    end else begin
      evtReg <= evtNext;
      irqReg <= |evtReg;
    end
  end

  assign evtView    = evtReg;
  assign IrqPending = irqReg;
`else
  assign evtView    = 5'd0;
  assign IrqPending = 1'b0;
`endif

  always_comb begin
    ReadData = '0;
    if (readHit) begin
      case (regSel)
        SEL_SW:  ReadData = {16'b0, debReg[15:0]};
        SEL_BTN: ReadData = {27'b0, debReg[20:16]};
        SEL_EVT: ReadData = {27'b0, evtView};
        SEL_LED: ReadData = {16'b0, ledReg};
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_input_responder.sv
// Bench for mmio_input_responder: vector table, hand-written debounce/event sequences and a
// randomized run against a sliding-window reference model.
module tb_mmio_input_responder;

  localparam int          DEB  = 16;
  localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef BTN_EVENT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [15:0] Sw;
  logic [4:0]  Btn;
  logic        Hit;
  logic [31:0] ReadData;
  logic [15:0] Led;
  logic        IrqPending;

  int checks   = 0;
  int failures = 0;

  mmio_input_responder #(
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .WriteData  (WriteData),
    .Sw         (Sw),
    .Btn        (Btn),
    .Hit        (Hit),
    .ReadData   (ReadData),
    .Led        (Led),
    .IrqPending (IrqPending)
  );

  always #5 Clk = ~Clk;

  // Reference model: inputs delayed two edges, and a window of the last DEB synchronized samples.
  logic [20:0] mS1, mS2, mDeb;
  logic [20:0] mWin[$];
  logic [4:0]  mEvt;
  logic        mIrq;
  logic [15:0] mLed;

  function automatic logic mHit(input logic [31:0] a);
    return (a >> 4) == (BASE >> 4);
  endfunction

  function automatic logic [31:0] mRead();
    if (!MemRead || MemWrite || !mHit(Address)) return 32'd0;
    case (Address[3:2])
      2'd0:    return {16'd0, mDeb[15:0]};
      2'd1:    return {27'd0, mDeb[20:16]};
      2'd2:    return {27'd0, mEvt};
      default: return {16'd0, mLed};
    endcase
  endfunction

  task automatic modelEdge();
    logic [20:0] newDeb;
    logic [4:0]  rise;
    logic [4:0]  clr;
    if (Rst) begin
      mS1 = '0; mS2 = '0; mDeb = '0; mEvt = '0; mIrq = 1'b0; mLed = '0;
      mWin.delete();
      repeat (DEB) mWin.push_back(21'd0);
    end else begin
      newDeb = mDeb;
      for (int i = 0; i < 21; i++) begin
        bit opp;
        opp = 1'b1;
        foreach (mWin[k]) if (mWin[k][i] == mDeb[i]) opp = 1'b0;
        if (opp) newDeb[i] = ~mDeb[i];
      end
      rise = newDeb[20:16] & ~mDeb[20:16];
      clr  = (MemWrite && mHit(Address) && Address[3:2] == 2'd2) ? WriteData[4:0] : 5'd0;
      if (MemWrite && mHit(Address) && Address[3:2] == 2'd3) mLed = WriteData[15:0];
      if (EVT_EN) begin
        mIrq = |mEvt;
        mEvt = (mEvt & ~clr) | rise;
      end
      mDeb = newDeb;
      mS2  = mS1;
      mS1  = {Btn, Sw};
      mWin.push_back(mS2);
      void'(mWin.pop_front());
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    chk("model_hit", {31'd0, Hit}, {31'd0, mHit(Address)});
    chk("model_rdata", ReadData, mRead());
    chk("model_led", {16'd0, Led}, {16'd0, mLed});
    chk("model_irq", {31'd0, IrqPending}, {31'd0, mIrq});
  endtask

  task automatic tick();
    @(posedge Clk);
    modelEdge();
    #1;
    compareModel();
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          expHit;
    logic [31:0] expRd;
    logic [15:0] expLed;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_200C, 32'h0,         1'b1, 32'h0,    16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_200C, 32'hABCD_1234, 1'b1, 32'h0,    16'h1234};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_200C, 32'h0,         1'b1, 32'h1234, 16'h1234};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         1'b0, 32'h0,    16'h1234};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_200C, 32'h0000_0055, 1'b1, 32'h0,    16'h0055};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_200F, 32'h0,         1'b1, 32'h0055, 16'h0055};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_2000, 32'h0000_FFFF, 1'b1, 32'h0,    16'h0055};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0,    16'h0055};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_201C, 32'h0000_7777, 1'b0, 32'h0,    16'h0055};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0,         1'b0, 32'h0,    16'h0055};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_200C, 32'h0,         1'b1, 32'h0,    16'h0055};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_2008, 32'h0,         1'b1, 32'h0,    16'h0055};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         1'b1, 32'h0,    16'h0055};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_2008, 32'h0000_001F, 1'b1, 32'h0,    16'h0055};

    Rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; WriteData = '0; Sw = '0; Btn = '0;
    tick();
    tick();
    Rst = 1'b0;

    // Register access table
    for (int i = 0; i < NVEC; i++) begin
      MemRead   = vecs[i].rd;
      MemWrite  = vecs[i].wr;
      Address   = vecs[i].addr;
      WriteData = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_hit", i), {31'd0, Hit}, {31'd0, vecs[i].expHit});
      chk($sformatf("vec%0d_rdata", i), ReadData, vecs[i].expRd);
      tick();
      chk($sformatf("vec%0d_led", i), {16'd0, Led}, {16'd0, vecs[i].expLed});
    end
    chk("reset_irq", {31'd0, IrqPending}, 32'd0);

    // Glitchy switch never gets through
    MemRead = 1'b1; MemWrite = 1'b0; Address = 32'h0000_2000;
    for (int c = 0; c < 100; c++) begin
      if (c % 5 == 0) Sw[3] = ~Sw[3];
      tick();
      chk("sw_glitch", ReadData, 32'd0);
    end
    Sw = '0;
    repeat (6) tick();

    // Stable change appears exactly 18 edges later
    Sw[3] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("sw_latency_k%0d", k), ReadData, (k >= 18) ? 32'h8 : 32'h0);
    end

    // Reset in the middle of a debounce discards the partial count
    Sw = 16'h0009;
    repeat (10) tick();
    Rst = 1'b1;
    tick();
    chk("rst_mid_rdata", ReadData, 32'd0);
    Rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("rst_restart_k%0d", k), ReadData, (k >= 18) ? 32'h9 : 32'h0);
    end

    // Button event and interrupt
    Address = 32'h0000_2008;
    Btn = 5'b00100;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("evt_set_k%0d", k), ReadData, (EVT_EN && k >= 18) ? 32'h4 : 32'h0);
      chk($sformatf("irq_set_k%0d", k), {31'd0, IrqPending}, (EVT_EN && k >= 19) ? 32'h1 : 32'h0);
    end
    Btn = '0;
    repeat (25) tick();
    chk("evt_after_release", ReadData, EVT_EN ? 32'h4 : 32'h0);
    MemRead = 1'b0; MemWrite = 1'b1; WriteData = 32'h4;
    tick();
    MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    chk("evt_clr", ReadData, 32'd0);
    chk("irq_hold", {31'd0, IrqPending}, EVT_EN ? 32'h1 : 32'h0);
    tick();
    chk("irq_clr", {31'd0, IrqPending}, 32'd0);

    // Set and clear of the same event bit on one edge
    Btn = 5'b00001;
    repeat (17) tick();
    MemRead = 1'b0; MemWrite = 1'b1; WriteData = 32'h1;
    tick();
    MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    chk("collide_evt", ReadData, EVT_EN ? 32'h1 : 32'h0);
    tick();
    chk("collide_irq", {31'd0, IrqPending}, EVT_EN ? 32'h1 : 32'h0);
    Btn = '0;
    repeat (20) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) Sw = 16'($urandom);
      if ($urandom_range(0, 29) == 0) Btn = 5'($urandom);
      MemRead   = 1'($urandom_range(0, 1));
      MemWrite  = ($urandom_range(0, 3) == 0);
      Address   = ($urandom_range(0, 4) == 0) ? 32'($urandom) : (BASE | 32'($urandom_range(0, 15)));
      WriteData = 32'($urandom);
      Rst       = ($urandom_range(0, 599) == 0);
      #1;
      compareModel();
      tick();
    end
    Rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
